// File: rtl/leaf_tx_packetizer.sv
// leaf_tx_packetizer: round-robin packetizer from user output streams
// to the BFT network, with per-port credit and sequence tracking.
module leaf_tx_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 3,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int CREDIT_INIT           = 128
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic                                  credit_update_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_update_port,
  input  logic                                  bft_ready,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic                                  credit_overflow
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int DW = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int RW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CW:0] C_INIT = (CW+1)'(CREDIT_INIT);
  localparam logic [CW:0] C_UPD  = (CW+1)'(FREESPACE_UPDATE_SIZE);

  logic [CW-1:0]            r_credit [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_seq    [NUM_OUT_PORTS];
  logic [RW-1:0]            r_rr;
  logic [PACKET_BITS-1:0]   r_dout;
  logic                     r_ovf;

  logic [NUM_OUT_PORTS-1:0] w_elig;
  logic [NUM_OUT_PORTS-1:0] w_ack;
  logic [NUM_OUT_PORTS-1:0] w_upd;
  logic [NUM_OUT_PORTS-1:0] w_clamp;
  logic [CW:0]              w_sum  [NUM_OUT_PORTS];
  logic [CW-1:0]            w_cnext[NUM_OUT_PORTS];
  logic                     w_grant;
  logic [RW-1:0]            w_gidx;
  logic [RW-1:0]            w_rr_next;

  function automatic int rot(input int b, input int k);
    int s;
    s = b + k;
    return (s >= NUM_OUT_PORTS) ? s - NUM_OUT_PORTS : s;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_elig[i] = vld_user2interface[i] && (r_credit[i] != '0);
    end
  end

  // First eligible port scanning upward from the rr pointer.
  always_comb begin
    w_ack   = '0;
    w_gidx  = '0;
    w_grant = 1'b0;
    if (!reset && bft_ready && !resend) begin
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        if (!w_grant && w_elig[rot(int'(r_rr), k)]) begin
          w_grant = 1'b1;
          w_gidx  = RW'(rot(int'(r_rr), k));
          w_ack[rot(int'(r_rr), k)] = 1'b1;
        end
      end
    end
  end

  assign w_rr_next = (w_gidx == RW'(NUM_OUT_PORTS-1)) ? '0
                                                       : w_gidx + 1'b1;

  // Net credit change; out-of-range update ports match no counter.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_upd[i]   = credit_update_vld &&
                   (credit_update_port == NUM_PORT_BITS'(i));
      w_sum[i]   = {1'b0, r_credit[i]}
                 + (w_upd[i] ? C_UPD : '0)
                 - (w_ack[i] ? (CW+1)'(1) : '0);
      w_clamp[i] = w_sum[i] > C_INIT;
      w_cnext[i] = w_clamp[i] ? C_INIT[CW-1:0] : w_sum[i][CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_rr   <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= C_INIT[CW-1:0];
        r_seq[i]    <= '0;
      end
    end else begin
      r_dout <= '0;
      if (w_grant) begin
        r_dout <= {1'b1,
                   dest_cfg[int'(w_gidx)*DW +: DW],
                   r_seq[w_gidx],
                   din_leaf_user2interface[int'(w_gidx)*PAYLOAD_BITS
                                           +: PAYLOAD_BITS]};
        r_seq[w_gidx] <= r_seq[w_gidx] + 1'b1;
        r_rr          <= w_rr_next;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= w_cnext[i];
      end
      if (|w_clamp) r_ovf <= 1'b1;
    end
  end

  assign ack_interface2user      = w_ack;
  assign dout_leaf_interface2bft = r_dout;
  assign credit_overflow         = r_ovf;

endmodule
